// File: rtl/ram_fifo_pkg.sv
// Shared types for the RAM FIFO stream reader: output-buffer occupancy states
// and the packet beat counter width.
package ram_fifo_pkg;

  typedef enum logic [1:0] {RD_EMPTY, RD_ONE, RD_TWO} rd_state_t;

  // Beat counter must be at least one bit wide, even for single-beat packets.
  function automatic int beat_cnt_w(input int pkt_len);
    return (pkt_len > 2) ? $clog2(pkt_len) : 1;
  endfunction

endpackage

// File: rtl/ram_fifo_stream_reader_if.sv
// FIFO dequeue signals plus the framed valid/ready stream of the stream reader.
// master = the reader block, slave = the FIFO/sink side.
interface ram_fifo_stream_reader_if #(
  parameter int DATA_W = 8
);
  logic              i_fifo_empty;
  logic [DATA_W-1:0] i_fifo_rddata;
  logic              o_fifo_rden;
  logic              o_tvalid;
  logic [DATA_W-1:0] o_tdata;
  logic              o_tlast;
  logic              i_tready;
  logic              o_pkt_done;

  modport master (
    input  i_fifo_empty, i_fifo_rddata, i_tready,
    output o_fifo_rden, o_tvalid, o_tdata, o_tlast, o_pkt_done
  );

  modport slave (
    output i_fifo_empty, i_fifo_rddata, i_tready,
    input  o_fifo_rden, o_tvalid, o_tdata, o_tlast, o_pkt_done
  );
endinterface

// File: rtl/ram_fifo_stream_reader.sv
// Drains the RAM FIFO into a framed valid/ready stream through a 2-entry buffer, 1 word/cycle;
// tvalid one cycle after FIFO goes non-empty; rden never depends on tready (pops stop at 2 buffered).
module ram_fifo_stream_reader
  import ram_fifo_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_en,
  ram_fifo_stream_reader_if.master bus
);

  localparam int               CNT_W     = beat_cnt_w(PKT_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  rd_state_t         state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              pkt_done_q, pkt_done_d;

  logic pop;
  logic accept;
  logic tvalid;
  logic tlast;

  // Pop decision uses only registered occupancy, so the sink's ready never reaches rden.
  assign pop    = i_en & ~bus.i_fifo_empty & (state_q != RD_TWO);
  assign tvalid = (state_q != RD_EMPTY);
  assign tlast  = tvalid & (beat_cnt_q == LAST_BEAT);
  assign accept = tvalid & bus.i_tready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      RD_EMPTY: begin
        if (pop) begin
          out_d   = bus.i_fifo_rddata;
          state_d = RD_ONE;
        end
      end
      RD_ONE: begin
        if (accept && pop) begin
          out_d = bus.i_fifo_rddata;
        end else if (accept) begin
          state_d = RD_EMPTY;
        end else if (pop) begin
          skid_d  = bus.i_fifo_rddata;
          state_d = RD_TWO;
        end
      end
      RD_TWO: begin
        if (accept) begin
          out_d   = skid_q;
          state_d = RD_ONE;
        end
      end
      default: state_d = RD_EMPTY;
    endcase
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (accept) begin
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
    end
  end

  assign pkt_done_d = accept & tlast;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= RD_EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      beat_cnt_q <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign bus.o_fifo_rden = pop;
  assign bus.o_tvalid    = tvalid;
  assign bus.o_tdata     = out_q;
  assign bus.o_tlast     = tlast;
  assign bus.o_pkt_done  = pkt_done_q;

endmodule

// File: tb/tb_ram_fifo_stream_reader.sv
// Bench for ram_fifo_stream_reader paired with a small RAM FIFO model (DEPTH=8).
module tb_ram_fifo_stream_reader;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       wr_en;
  logic [7:0] wr_dat;

  ram_fifo_stream_reader_if #(.DATA_W(8)) bus ();

  ram_fifo_stream_reader #(.DATA_W(8), .PKT_LEN(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .i_en (en),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM FIFO model: registered pointers, combinational read data from the read pointer.
  logic [7:0] mem [8];
  logic [2:0] wp, rp;
  logic [3:0] fcnt;
  logic       wr_ok, rd_ok;

  assign wr_ok             = wr_en & en & rstn & (fcnt < 4'd8);
  assign rd_ok             = bus.o_fifo_rden & en & (fcnt != 4'd0);
  assign bus.i_fifo_empty  = (fcnt == 4'd0);
  assign bus.i_fifo_rddata = mem[rp];

  always @(posedge clk) begin
    if (!rstn) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      if (wr_ok) begin
        mem[wp] <= wr_dat;
        wp      <= wp + 3'd1;
      end
      if (rd_ok) rp <= rp + 3'd1;
      fcnt <= fcnt + {3'd0, wr_ok} - {3'd0, rd_ok};
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: words written but not yet accepted, in order; occupancy = popped - accepted.
  logic [7:0] exp_q[$];
  int         buffered  = 0;
  int         beat_idx  = 0;
  logic       exp_pd    = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat  = '0;
  logic       prev_last = 1'b0;
  int         mon_acc   = 0;
  int         pd_cnt    = 0;
  int         cyc       = 0;
  logic [7:0] log_dat[$];
  logic       log_last[$];
  int         log_cyc[$];

  always @(negedge clk) begin
    logic acc, last_exp;
    cyc++;
    if (!rstn) begin
      exp_q.delete();
      buffered   = 0;
      beat_idx   = 0;
      exp_pd     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("pkt_done", int'(bus.o_pkt_done), int'(exp_pd));
      chk("tvalid_vs_occupancy", int'(bus.o_tvalid), int'(buffered > 0));
      chk("rden_rule", int'(bus.o_fifo_rden), int'(en & ~bus.i_fifo_empty & (buffered < 2)));
      chk("rden_while_empty", int'(bus.o_fifo_rden & bus.i_fifo_empty), 0);
      if (bus.o_pkt_done) pd_cnt++;
      if (prev_stall) begin
        chk("stall_tvalid", int'(bus.o_tvalid), 1);
        chk("stall_tdata", int'(bus.o_tdata), int'(prev_dat));
        chk("stall_tlast", int'(bus.o_tlast), int'(prev_last));
      end
      if (wr_ok) exp_q.push_back(wr_dat);
      acc      = bus.o_tvalid & bus.i_tready;
      last_exp = 1'b0;
      if (acc) begin
        last_exp = ((beat_idx % 4) == 3);
        if (exp_q.size() == 0) begin
          chk("beat_without_word", 1, 0);
        end else begin
          chk("beat_data", int'(bus.o_tdata), int'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        chk("beat_tlast", int'(bus.o_tlast), int'(last_exp));
        log_dat.push_back(bus.o_tdata);
        log_last.push_back(bus.o_tlast);
        log_cyc.push_back(cyc);
        beat_idx++;
        mon_acc++;
      end
      exp_pd     = acc & last_exp;
      buffered   = buffered + int'(bus.o_fifo_rden) - int'(acc);
      prev_stall = bus.o_tvalid & ~bus.i_tready;
      prev_dat   = bus.o_tdata;
      prev_last  = bus.o_tlast;
    end
  end

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rdy;
    logic       e_vld;
    logic [7:0] e_dat;
    logic       e_last;
    logic       e_rden;
    logic       e_pd;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, lim, lbase;
    logic wr_done;

    // Backpressure script from an empty, packet-aligned start.
    tbl[0]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 8'h12, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 8'h13, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h13, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

    rstn         = 1'b0;
    en           = 1'b1;
    wr_en        = 1'b0;
    wr_dat       = '0;
    bus.i_tready = 1'b0;

    // 1. Reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tvalid", int'(bus.o_tvalid), 0);
      chk("rst_rden", int'(bus.o_fifo_rden), 0);
      chk("rst_pkt_done", int'(bus.o_pkt_done), 0);
      chk("rst_tdata", int'(bus.o_tdata), 0);
      chk("rst_tlast", int'(bus.o_tlast), 0);
      chk("rst_fcnt", int'(fcnt), 0);
    end
    step();
    rstn = 1'b1;
    repeat (2) step();

    // 2. Back-to-back stream
    lbase        = log_dat.size();
    base         = pd_cnt;
    bus.i_tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_en  = 1'b1;
      wr_dat = 8'(i);
      step();
    end
    wr_en = 1'b0;
    lim   = 0;
    while (log_dat.size() - lbase < 8 && lim < 40) begin step(); lim++; end
    repeat (3) step();
    chk("s2_beats", log_dat.size() - lbase, 8);
    for (int i = 0; i < 8 && lbase + i < log_dat.size(); i++) begin
      chk("s2_data", int'(log_dat[lbase+i]), i + 1);
      chk("s2_last", int'(log_last[lbase+i]), int'(i == 3 || i == 7));
      if (i > 0) chk("s2_no_bubble", log_cyc[lbase+i] - log_cyc[lbase+i-1], 1);
    end
    chk("s2_pkt_done_count", pd_cnt - base, 2);
    chk("s2_fifo_empty", int'(fcnt), 0);

    // 3. Backpressure, cycle by cycle
    for (int i = 0; i < 11; i++) begin
      step();
      wr_en        = tbl[i].wr;
      wr_dat       = tbl[i].wd;
      bus.i_tready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("s3_tvalid[%0d]", i), int'(bus.o_tvalid), int'(tbl[i].e_vld));
      chk($sformatf("s3_rden[%0d]", i), int'(bus.o_fifo_rden), int'(tbl[i].e_rden));
      chk($sformatf("s3_tlast[%0d]", i), int'(bus.o_tlast), int'(tbl[i].e_last));
      chk($sformatf("s3_pkt_done[%0d]", i), int'(bus.o_pkt_done), int'(tbl[i].e_pd));
      if (tbl[i].e_vld) chk($sformatf("s3_tdata[%0d]", i), int'(bus.o_tdata), int'(tbl[i].e_dat));
    end
    step();
    wr_en = 1'b0;
    repeat (2) step();

    // 4. Enable gating: 2 buffered, 3 in FIFO, then i_en low
    bus.i_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en  = 1'b1;
      wr_dat = 8'(8'h30 + i);
      step();
    end
    wr_en = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("s4_fifo_holds3", int'(fcnt), 3);
    chk("s4_buffer_full_valid", int'(bus.o_tvalid), 1);
    step();
    base         = mon_acc;
    en           = 1'b0;
    bus.i_tready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    chk("s4_gated_beats", mon_acc - base, 2);
    chk("s4_gated_tvalid", int'(bus.o_tvalid), 0);
    chk("s4_gated_fcnt", int'(fcnt), 3);
    step();
    en  = 1'b1;
    lim = 0;
    while (mon_acc - base < 5 && lim < 20) begin step(); lim++; end
    chk("s4_resume_beats", mon_acc - base, 5);

    // 5. Reset mid-packet: realign to a packet boundary first
    for (int i = 0; i < 3; i++) begin
      wr_en  = 1'b1;
      wr_dat = 8'(8'h3a + i);
      step();
    end
    wr_en = 1'b0;
    repeat (6) step();
    bus.i_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en  = 1'b1;
      wr_dat = 8'(8'h40 + i);
      step();
    end
    wr_en = 1'b0;
    repeat (3) step();
    base         = mon_acc;
    bus.i_tready = 1'b1;
    lim          = 0;
    while (mon_acc - base < 2 && lim < 20) begin step(); lim++; end
    bus.i_tready = 1'b0;
    chk("s5_partial_beats", mon_acc - base, 2);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    @(negedge clk);
    chk("s5_rst_tvalid", int'(bus.o_tvalid), 0);
    chk("s5_rst_tlast", int'(bus.o_tlast), 0);
    step();
    lbase        = log_dat.size();
    bus.i_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en  = 1'b1;
      wr_dat = 8'(8'h20 + i);
      step();
    end
    wr_en = 1'b0;
    lim   = 0;
    while (log_dat.size() - lbase < 4 && lim < 20) begin step(); lim++; end
    chk("s5_beats", log_dat.size() - lbase, 4);
    for (int i = 0; i < 4 && lbase + i < log_dat.size(); i++) begin
      chk("s5_data", int'(log_dat[lbase+i]), 8'h20 + i);
      chk("s5_last", int'(log_last[lbase+i]), int'(i == 3));
    end
    repeat (2) step();

    // 6. Random ready and write gaps against the scoreboard
    base    = mon_acc;
    wr_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          int gap, w;
          gap = $urandom_range(0, 3);
          repeat (gap) step();
          w = 0;
          while (fcnt >= 4'd8 && w < 1000) begin step(); w++; end
          wr_en  = 1'b1;
          wr_dat = 8'($urandom);
          step();
          wr_en = 1'b0;
        end
        wr_done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while (!(wr_done && exp_q.size() == 0) && n < 6000) begin
          bus.i_tready = 1'($urandom_range(0, 1));
          step();
          n++;
        end
        chk("s6_drain_in_time", int'(n < 6000), 1);
      end
    join
    bus.i_tready = 1'b0;
    repeat (3) step();
    chk("s6_beats", mon_acc - base, 200);
    chk("s6_fifo_empty", int'(fcnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
